// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N_MASTER masters share one slave, grant locked for the whole cyc.
// Latency: grant one cycle after cyc is seen in IDLE; ack/err/dat pass through combinationally.
// Backpressure: the slave stalls the owner via ack/err; a stall watchdog aborts with err after TIMEOUT cycles.
module wb_rr_arbiter #(
   parameter int N_MASTER = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_MASTER-1:0]     m_cyc_i,
   input  logic [N_MASTER-1:0]     m_stb_i,
   input  logic [N_MASTER-1:0]     m_we_i,
   input  logic [32*N_MASTER-1:0]  m_adr_i,
   input  logic [32*N_MASTER-1:0]  m_dat_i,
   input  logic [4*N_MASTER-1:0]   m_sel_i,
   output logic [31:0]             m_dat_o,
   output logic [N_MASTER-1:0]     m_ack_o,
   output logic [N_MASTER-1:0]     m_err_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic                    s_we_o,
   output logic [31:0]             s_adr_o,
   output logic [31:0]             s_dat_o,
   output logic [3:0]              s_sel_o,
   input  logic [31:0]             s_dat_i,
   input  logic                    s_ack_i,
   input  logic                    s_err_i,
   output logic [N_MASTER-1:0]     gnt_o,
   output logic                    timeout_o
);

   localparam int LW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // The abort decision is taken in the T-th stall cycle, so compare against T-1 before incrementing.
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

   state_t              r_state;
   logic [N_MASTER-1:0] r_gnt;
   logic [LW-1:0]       r_last;
   logic [CW-1:0]       r_cnt;

   logic                w_busy;
   logic                w_abort;
   logic                w_stall;
   logic                w_pick_vld;
   logic [LW-1:0]       w_pick_idx;
   logic [LW-1:0]       w_scan;
   int                  w_g;

   logic [31:0]         w_adr [N_MASTER];
   logic [31:0]         w_dat [N_MASTER];
   logic [3:0]          w_sel [N_MASTER];

   for (genvar i = 0; i < N_MASTER; i++) begin : g_unpack
      assign w_adr[i] = m_adr_i[32*i +: 32];
      assign w_dat[i] = m_dat_i[32*i +: 32];
      assign w_sel[i] = m_sel_i[4*i +: 4];
   end

   assign w_g     = int'(r_last);
   assign w_busy  = (r_state == BUSY);
   assign w_abort = (r_state == ABORT);

   // Round-robin pick: scan last+N down to last+1 so the nearest requester after last wins.
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick_idx = '0;
      w_scan     = '0;
      for (int k = N_MASTER; k >= 1; k--) begin
         w_scan = LW'((w_g + k) % N_MASTER);
         if (m_cyc_i[w_scan]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = w_scan;
         end
      end
   end

   // Slave side follows the owner only while BUSY; ABORT and IDLE present an idle bus.
   assign s_cyc_o = w_busy & m_cyc_i[r_last];
   assign s_stb_o = w_busy & m_stb_i[r_last];
   assign s_we_o  = w_busy & m_we_i[r_last];
   assign s_adr_o = w_busy ? w_adr[r_last] : '0;
   assign s_dat_o = w_busy ? w_dat[r_last] : '0;
   assign s_sel_o = w_busy ? w_sel[r_last] : '0;

   assign w_stall = s_stb_o & ~s_ack_i & ~s_err_i;

   // Responses go to the owner only; a watchdog abort reuses the err line.
   assign m_ack_o   = (w_busy & s_ack_i) ? r_gnt : '0;
   assign m_err_o   = ((w_busy & s_err_i) | w_abort) ? r_gnt : '0;
   assign m_dat_o   = s_dat_i;
   assign gnt_o     = r_gnt;
   assign timeout_o = w_abort;

   // Arbitration FSM with grant ownership and stall watchdog.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_last  <= LW'(N_MASTER - 1);
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (w_pick_vld) begin
                  r_gnt   <= N_MASTER'(1) << w_pick_idx;
                  r_last  <= w_pick_idx;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (!m_cyc_i[r_last]) begin
                  r_gnt   <= '0;
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else if (s_ack_i || s_err_i) begin
                  r_cnt <= '0;
               end else if (w_stall && (TIMEOUT != 0)) begin
                  if (r_cnt == CNT_LAST) begin
                     r_cnt   <= '0;
                     r_state <= ABORT;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            ABORT: begin
               r_cnt <= '0;
               if (m_cyc_i[r_last]) begin
                  r_state <= BUSY;
               end else begin
                  r_gnt   <= '0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_gnt   <= '0;
               r_cnt   <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios with literal expectations plus randomized traffic.
// Outputs are compared every cycle on the falling edge against a queue/int-level model of the arbiter.
// Inputs change 1ns after the rising edge.
module tb_wb_rr_arbiter;

   localparam int N  = 4;
   localparam int TO = 4;

   logic              clk = 1'b0;
   logic              rst_i;
   logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
   logic [32*N-1:0]   m_adr_i, m_dat_i;
   logic [4*N-1:0]    m_sel_i;
   logic [31:0]       m_dat_o;
   logic [N-1:0]      m_ack_o, m_err_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [31:0]       s_adr_o, s_dat_o;
   logic [3:0]        s_sel_o;
   logic [31:0]       s_dat_i;
   logic              s_ack_i, s_err_i;
   logic [N-1:0]      gnt_o;
   logic              timeout_o;

   int checks   = 0;
   int failures = 0;

   wb_rr_arbiter #(.N_MASTER(N), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .gnt_o(gnt_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   logic [115:0] dut_v;
   assign dut_v = {m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o,
                   s_adr_o, s_dat_o, s_sel_o, gnt_o, timeout_o};

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // owner = -1 when nobody holds the bus; aborting marks the single abort cycle.
   int md_owner = -1;
   int md_last  = N - 1;
   int md_stall = 0;
   bit md_abort = 1'b0;
   bit md_valid = 1'b0;

   always @(negedge clk) begin
      logic [115:0] ev;
      logic [3:0]   e_gnt, e_ack, e_err;
      bit           busy;
      int           gi, c;
      gi    = (md_owner < 0) ? 0 : md_owner;
      busy  = (md_owner >= 0) && !md_abort;
      e_gnt = (md_owner >= 0) ? (4'b0001 << md_owner) : 4'b0000;
      e_ack = (busy && s_ack_i) ? e_gnt : 4'b0000;
      e_err = ((busy && s_err_i) || md_abort) ? e_gnt : 4'b0000;
      ev = {s_dat_i, e_ack, e_err,
            busy & m_cyc_i[gi], busy & m_stb_i[gi], busy & m_we_i[gi],
            busy ? m_adr_i[32*gi +: 32] : 32'h0,
            busy ? m_dat_i[32*gi +: 32] : 32'h0,
            busy ? m_sel_i[4*gi +: 4] : 4'h0,
            e_gnt, md_abort};
      if (md_valid) chk("model", 128'(dut_v), 128'(ev));

      if (rst_i) begin
         md_owner = -1; md_last = N - 1; md_stall = 0; md_abort = 1'b0; md_valid = 1'b1;
      end else if (md_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            c = (md_last + k) % N;
            if (md_owner < 0 && m_cyc_i[c]) begin
               md_owner = c;
               md_last  = c;
            end
         end
      end else if (md_abort) begin
         md_abort = 1'b0;
         if (!m_cyc_i[md_owner]) md_owner = -1;
      end else if (!m_cyc_i[md_owner]) begin
         md_owner = -1;
         md_stall = 0;
      end else if (s_ack_i || s_err_i) begin
         md_stall = 0;
      end else if (m_stb_i[md_owner]) begin
         md_stall++;
         if (md_stall == TO) begin
            md_abort = 1'b1;
            md_stall = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
      s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
   endtask

   task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      m_cyc_i[i] = cyc;
      m_stb_i[i] = stb;
      m_we_i[i]  = we;
      m_adr_i[32*i +: 32] = adr;
      m_dat_i[32*i +: 32] = dat;
      m_sel_i[4*i +: 4]   = sel;
   endtask

   task automatic run_directed();
      logic [3:0] eg;
      int g;
      // Reset state and a lone request from master 2.
      do_reset();
      settle();
      chk("reset_outputs", 128'(dut_v), 128'(0));
      set_m(2, 1, 1, 1, 32'hA2A2_0002, 32'hD2D2_0002, 4'hC);
      settle();
      chk("gnt_same_cycle", 128'(gnt_o), 128'(0));
      step(); settle();
      chk("gnt_latency", 128'(gnt_o), 128'(4'b0100));
      chk("slave_adr", 128'(s_adr_o), 128'(32'hA2A2_0002));
      chk("slave_dat", 128'(s_dat_o), 128'(32'hD2D2_0002));
      chk("slave_ctl", 128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 128'(7'b111_1100));
      step(); settle();
      chk("no_ack_yet", 128'(m_ack_o), 128'(0));
      step();
      s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
      settle();
      chk("ack_routed", 128'(m_ack_o), 128'(4'b0100));
      chk("rdata", 128'(m_dat_o), 128'(32'h1234_5678));
      step();
      s_ack_i = 1'b0; m_cyc_i[2] = 1'b0;
      settle();
      chk("ack_one_cycle", 128'(m_ack_o), 128'(0));
      step(); settle();
      chk("release", 128'(gnt_o), 128'(0));

      // All masters requesting: 0,1,2,3,0 with one dead cycle between tenures.
      do_reset();
      for (int i = 0; i < N; i++) set_m(i, 1, 1, 0, 32'h1000_0000 + i, 32'h0, 4'hF);
      for (int r = 0; r < 5; r++) begin
         g  = r % N;
         eg = 4'b0001 << g;
         step(); settle();
         chk("rr_grant", 128'(gnt_o), 128'(eg));
         s_ack_i = 1'b1; m_cyc_i[g] = 1'b0;
         step();
         s_ack_i = 1'b0;
         settle();
         chk("rr_gap", 128'(gnt_o), 128'(0));
         m_cyc_i[g] = 1'b1;
      end

      // Master 1 locks the bus across three transfers while master 0 waits.
      do_reset();
      set_m(1, 1, 1, 1, 32'h0000_1111, 32'hCAFE_0001, 4'h3);
      step(); settle();
      chk("lock_grant", 128'(gnt_o), 128'(4'b0010));
      set_m(0, 1, 1, 0, 32'h0000_0000, 32'h0, 4'hF);
      for (int j = 0; j < 3; j++) begin
         s_ack_i = 1'b1;
         step();
         s_ack_i = 1'b0;
         settle();
         chk("lock_keep", 128'(gnt_o), 128'(4'b0010));
         step();
      end
      m_cyc_i[1] = 1'b0;
      step(); settle();
      chk("lock_gap", 128'(gnt_o), 128'(0));
      step(); settle();
      chk("lock_next", 128'(gnt_o), 128'(4'b0001));

      // Watchdog: master 3 stalls four cycles, abort in the fifth.
      do_reset();
      set_m(3, 1, 1, 0, 32'h3333_0000, 32'h0, 4'hF);
      step(); step(); step(); step();
      settle();
      chk("wd_before", 128'({timeout_o, m_err_o}), 128'(0));
      step();
      s_ack_i = 1'b1;
      settle();
      chk("wd_err", 128'(m_err_o), 128'(4'b1000));
      chk("wd_pulse", 128'(timeout_o), 128'(1));
      chk("wd_scyc", 128'({s_cyc_o, s_stb_o}), 128'(0));
      chk("wd_late_ack", 128'(m_ack_o), 128'(0));
      step();
      s_ack_i = 1'b0;
      settle();
      chk("wd_resume", 128'({s_cyc_o, timeout_o, gnt_o}), 128'(6'b10_1000));
      // Ack in the 4th cycle prevents the abort and clears the count.
      step(); step(); step();
      s_ack_i = 1'b1;
      settle();
      chk("wd_ack_fwd", 128'({m_ack_o, timeout_o}), 128'(5'b1000_0));
      step();
      s_ack_i = 1'b0;
      settle();
      chk("wd_no_abort", 128'(timeout_o), 128'(0));
      step(); step(); step(); settle();
      chk("wd_cnt_cleared", 128'(timeout_o), 128'(0));
      step(); settle();
      chk("wd_second_abort", 128'(timeout_o), 128'(1));
      step();
      s_err_i = 1'b1;
      settle();
      chk("err_fwd", 128'({m_err_o, timeout_o}), 128'(5'b1000_0));
      // Reset mid-transfer with an ack in flight.
      step();
      s_err_i = 1'b0; s_ack_i = 1'b1; rst_i = 1'b1;
      step();
      rst_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; s_dat_i = '0;
      settle();
      chk("rst_mid", 128'(dut_v), 128'(0));
      step();
      s_ack_i = 1'b0; m_cyc_i = '1;
      step(); settle();
      chk("rst_prio", 128'(gnt_o), 128'(4'b0001));
   endtask

   task automatic run_random(input int cycles);
      do_reset();
      for (int n = 0; n < cycles; n++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(7) == 0) m_cyc_i[i] = ~m_cyc_i[i];
            m_stb_i[i] = ($urandom_range(3) != 0);
            m_we_i[i]  = $urandom_range(1) == 1;
            m_adr_i[32*i +: 32] = $urandom;
            m_dat_i[32*i +: 32] = $urandom;
            m_sel_i[4*i +: 4]   = 4'($urandom_range(15));
         end
         s_dat_i = $urandom;
         s_ack_i = ($urandom_range(2) == 0);
         s_err_i = ($urandom_range(15) == 0);
         rst_i   = ($urandom_range(299) == 0);
      end
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b0;
      idle_inputs();
      run_directed();
      run_random(3000);
      idle_inputs();
      step();
      step();
      #5;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone arbiter that shares one slave port among `N_MASTER` masters, with bus locking for the whole `cyc` period and a stall watchdog. It sits between bus masters and a single shared resource where a full `wb_xbar` is unnecessary. Typical uses are the core IF/LSU/cache ports and the debug module contending for one `wb_ram_wrapper`, or several masters in front of `wb2apb`. A granted master owns the slave until it drops `cyc`. A slave that never answers is aborted with `err` so the bus cannot deadlock.

## Interface
- `N_MASTER`, 4: number of requesting masters (2..8).
- `TIMEOUT`, 255: stall cycles (`stb` high, no `ack`/`err`) before abort; 0 disables the watchdog.
- `clk_i` in 1: system clock; all logic is on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `m_cyc_i` in N_MASTER: per-master cycle request.
- `m_stb_i` in N_MASTER: per-master strobe.
- `m_we_i` in N_MASTER: per-master write enable.
- `m_adr_i` in 32*N_MASTER: master i uses bits [32i+31:32i].
- `m_dat_i` in 32*N_MASTER: write data, packed the same way.
- `m_sel_i` in 4*N_MASTER: byte selects, [4i+3:4i].
- `m_dat_o` out 32: read data, broadcast to all masters.
- `m_ack_o` out N_MASTER: ack, routed to the granted master only.
- `m_err_o` out N_MASTER: error, routed to the granted master only, or the watchdog abort.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: shared slave controls.
- `s_adr_o` out 32, `s_dat_o` out 32, `s_sel_o` out 4: shared slave address, write data and byte selects.
- `s_dat_i` in 32, `s_ack_i` in 1, `s_err_i` in 1: slave response.
- `gnt_o` out N_MASTER: one-hot current grant, registered.
- `timeout_o` out 1: one-cycle pulse when the watchdog aborts.

## Operation
- FSM states are IDLE, BUSY and ABORT. Registers:
  - `gnt` (one-hot),
  - `last` (index of the last granted master),
  - stall counter of width clog2(TIMEOUT+1).
- **IDLE**
  - If any `m_cyc_i` is set, grant the first requesting master scanning `last+1, last+2, …` modulo N_MASTER.
  - Load `gnt` and `last`, then go to BUSY. Otherwise stay.
- **BUSY**
  - Slave outputs = granted master's inputs; `s_cyc_o` = `m_cyc_i[g]`.
  - `m_ack_o[g]` = `s_ack_i`, `m_err_o[g]` = `s_err_i`. All other `ack`/`err` bits are 0.
  - If `m_cyc_i[g]` = 0: clear `gnt` and go to IDLE.
- **Watchdog (BUSY, TIMEOUT ≠ 0)**
  - Counter +1 in each cycle with `s_stb_o` = 1 and `s_ack_i` = `s_err_i` = 0.
  - Counter clears on `ack`, `err`, or leaving BUSY.
  - When the counter equals TIMEOUT, go to ABORT.
- **ABORT**
  - Lasts exactly one cycle: `s_cyc_o` = `s_stb_o` = 0, `m_err_o[g]` = 1, `timeout_o` = 1.
  - Any `s_ack_i`/`s_err_i` arriving in this state is ignored.
  - Next state is BUSY if `m_cyc_i[g]` is still set, otherwise IDLE with `gnt` cleared.
- **Slave outputs outside BUSY**
  - All slave outputs are 0 outside BUSY; `s_adr_o`/`s_dat_o`/`s_sel_o` are 0 when not granted.
  - `m_dat_o` = `s_dat_i` at all times.

## Timing
- **Reset:** all outputs 0, state IDLE, counter 0, `last` = N_MASTER-1 (master 0 has first priority).
- **Grant latency:** `cyc` seen in IDLE at cycle t → `gnt_o` and `s_cyc_o` at t+1. A single requester owns the slave from t+1.
- **Response path:** `ack`/`err`/`dat` pass through combinationally in BUSY, adding zero cycles.
- **Release:** `cyc` drop at cycle t → IDLE at t+1 → next grant at t+2. There is always one dead cycle between owners, and at least one when the same master re-requests.
- **Fairness:** the scan starts after `last`, so with all masters requesting continuously the grant order is 0,1,…,N-1,0. No master waits more than N-1 tenures.
- **Simultaneous events:**
  - `ack` and counter = TIMEOUT in the same cycle: `ack` wins, counter clears, no abort.
  - `ack` and `cyc` drop in the same cycle: the transfer completes and the next state is IDLE.
  - Requests arriving during BUSY are ignored until IDLE.
- **Abort timing:** with TIMEOUT = T, stalled `stb` cycles 1..T give `m_err_o[g]` and `timeout_o` in cycle T+1.
- **Reset mid-transfer:** the next edge forces IDLE and zero outputs; any in-flight `ack` is dropped.

## Test plan
- Reset, then master 2 requests alone; slave acks after 3 cycles → `gnt_o` = 0100 one cycle after `cyc`. Master 2's address/data appear on the slave. `m_ack_o` = 0100 for exactly one cycle, all other `ack` bits 0.
- All 4 masters hold `cyc` and each drops it after its single ack → grant sequence 0,1,2,3,0. There is exactly one cycle with `gnt_o` = 0 between each tenure.
- Master 1 holds `cyc` across 3 `stb`/`ack` transfers while master 0 requests → master 1 keeps the grant until its `cyc` drops; master 0 is granted 2 cycles later.
- TIMEOUT = 4, slave never acks → `m_err_o[g]` and `timeout_o` pulse high in the 5th stall cycle, `s_cyc_o` = 0 in that cycle. A late `s_ack_i` there does not reach `m_ack_o`.
- TIMEOUT = 4, `ack` in the 4th stall cycle → no abort and the counter returns to 0. A slave `err` is forwarded as `m_err_o` to the granted master only.
- `rst_i` asserted mid-transfer with grant on master 3 → next cycle all outputs 0; a subsequent all-masters request grants master 0 first.
